// File: rtl/soc_sysctl_pkg.sv
// soc_sysctl_pkg -- shared constants for the system-control block.
// Holds the OCP bus widths and command/response codes, the register map
// offsets, the software-reset key, the unmapped-read pattern, the SoC info
// constants, the request struct and the byte-lane merge helper.
package soc_sysctl_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  // OCP command / response codes
  localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
  localparam logic [2:0] OCP_CMD_WR    = 3'd1;
  localparam logic [2:0] OCP_CMD_RD    = 3'd2;
  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA  = 2'd1;

  // register map
  localparam logic [ADDR_WIDTH-1:0] OFS_VERSION  = 12'h000;
  localparam logic [ADDR_WIDTH-1:0] OFS_RAM_BASE = 12'h004;
  localparam logic [ADDR_WIDTH-1:0] OFS_RAM_SIZE = 12'h008;
  localparam logic [ADDR_WIDTH-1:0] OFS_ROM_SIZE = 12'h00C;
  localparam logic [ADDR_WIDTH-1:0] OFS_SYS_FREQ = 12'h010;
  localparam logic [ADDR_WIDTH-1:0] OFS_CAPS     = 12'h014;
  localparam logic [ADDR_WIDTH-1:0] OFS_CYCLO    = 12'h020;
  localparam logic [ADDR_WIDTH-1:0] OFS_CYCHI    = 12'h024;
  localparam logic [ADDR_WIDTH-1:0] OFS_SCRATCH  = 12'h030;
  localparam logic [ADDR_WIDTH-1:0] OFS_SWRST    = 12'h040;
  localparam logic [ADDR_WIDTH-1:0] OFS_LED      = 12'h100;
  localparam logic [ADDR_WIDTH-1:0] OFS_BLINK    = 12'h104;
  localparam logic [ADDR_WIDTH-1:0] OFS_PERIOD   = 12'h108;

  localparam logic [7:0]            SWRST_KEY   = 8'hA5;
  localparam logic [DATA_WIDTH-1:0] RD_UNMAPPED = 32'hDEAD_DEAD;

  // SoC info constants
  localparam logic [DATA_WIDTH-1:0] SOC_VERSION  = 32'h0001_0200;
  localparam logic [DATA_WIDTH-1:0] SOC_RAM_BASE = 32'h2000_0000;
  localparam logic [DATA_WIDTH-1:0] SOC_RAM_SIZE = 32'h0001_0000;
  localparam logic [DATA_WIDTH-1:0] SOC_ROM_SIZE = 32'h0000_8000;
  localparam logic [DATA_WIDTH-1:0] SOC_SYS_FREQ = 32'd50_000_000;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BEN_WIDTH-1:0]  ben;
  } ocp_req_t;

  // replace only the byte lanes whose enable is set
  function automatic logic [DATA_WIDTH-1:0] ben_merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [BEN_WIDTH-1:0]  ben
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < BEN_WIDTH; i++)
      if (ben[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/soc_sysctl_blink.sv
// soc_sysctl_blink -- LED blink prescaler and phase generator.
// Ports: clk/nrst (async active-low), load (PERIOD register written this
// cycle), load_val (value being written), period (current PERIOD),
// phase (1 = LEDs steady, 0 = blink-masked LEDs off).
// The down-counter reloads from period on reaching 0 and toggles phase, so
// each phase lasts period+1 cycles. period==0 parks phase at 1.
module soc_sysctl_blink #(
  parameter int PRESC_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   load,
  input  logic [PRESC_WIDTH-1:0] load_val,
  input  logic [PRESC_WIDTH-1:0] period,
  output logic                   phase
);

  logic [PRESC_WIDTH-1:0] presc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (load) begin
      // new PERIOD restarts the sequence from the lit phase
      presc <= load_val;
      phase <= 1'b1;
    end else if (period == '0) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (presc == '0) begin
      presc <= period;
      phase <= ~phase;
    end else begin
      presc <= presc - PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/soc_sysctl.sv
// soc_sysctl -- SoC system-control register block on an OCP slave port.
// Ports: clk, nrst (async active-low); OCP i_MAddr/i_MCmd/i_MData/i_MByteEn
// in, o_SCmdAccept (always 1), o_SData/o_SResp registered one cycle after
// the request; o_LED LED drive; o_swrst software-reset pulse.
// Provides SoC info constants, a 64-bit cycle counter with a high-word
// shadow latched on CYCLO reads, scratch, keyed software reset, LEDs.
// Build option: SOC_SYSCTL_BLINK_EN adds the BLINK mask / PERIOD registers
// and the blink prescaler; without it they read 0 and phase stays 1.
module soc_sysctl
  import soc_sysctl_pkg::*;
#(
  parameter int NLED        = 8,
  parameter int PRESC_WIDTH = 24,
  parameter int RST_PULSE   = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp,
  output logic [NLED-1:0]       o_LED,
  output logic                  o_swrst
);

  ocp_req_t               req;
  logic                   rd, wr;
  logic [63:0]            cyc_cnt;
  logic [DATA_WIDTH-1:0]  cyc_shadow, scratch, rdata, caps;
  logic [NLED-1:0]        led_r, blink_r, led_w;
  logic [PRESC_WIDTH-1:0] period_r;
  logic [7:0]             swrst_cnt;
  logic                   phase, swrst_hit;

  assign req = '{cmd: i_MCmd, addr: i_MAddr, data: i_MData, ben: i_MByteEn};
  assign rd  = (req.cmd == OCP_CMD_RD);
  assign wr  = (req.cmd == OCP_CMD_WR);
  assign o_SCmdAccept = 1'b1;

  assign led_w     = NLED'(ben_merge(DATA_WIDTH'(led_r), req.data, req.ben));
  assign swrst_hit = wr && (req.addr == OFS_SWRST) && req.ben[0] &&
                     (req.data[7:0] == SWRST_KEY);

`ifdef SOC_SYSCTL_BLINK_EN
  localparam logic BLINK_PRESENT = 1'b1;

  logic [NLED-1:0]        blink_w;
  logic [PRESC_WIDTH-1:0] period_w;
  logic                   period_wr;

  assign blink_w   = NLED'(ben_merge(DATA_WIDTH'(blink_r), req.data, req.ben));
  assign period_w  = PRESC_WIDTH'(ben_merge(DATA_WIDTH'(period_r), req.data, req.ben));
  assign period_wr = wr && (req.addr == OFS_PERIOD);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_r  <= '0;
      period_r <= '0;
    end else begin
      if (wr && (req.addr == OFS_BLINK)) blink_r <= blink_w;
      if (period_wr)                     period_r <= period_w;
    end
  end

  soc_sysctl_blink #(.PRESC_WIDTH(PRESC_WIDTH)) u_blink (
    .clk      (clk),
    .nrst     (nrst),
    .load     (period_wr),
    .load_val (period_w),
    .period   (period_r),
    .phase    (phase)
  );
`else
  localparam logic BLINK_PRESENT = 1'b0;

  assign blink_r  = '0;
  assign period_r = '0;
  assign phase    = 1'b1;
`endif

  always_comb begin
    caps      = '0;
    caps[5:0] = 6'(NLED);
    caps[8]   = BLINK_PRESENT;
  end

  // read mux sees register state before this cycle's update
  always_comb begin
    case (req.addr)
      OFS_VERSION:  rdata = SOC_VERSION;
      OFS_RAM_BASE: rdata = SOC_RAM_BASE;
      OFS_RAM_SIZE: rdata = SOC_RAM_SIZE;
      OFS_ROM_SIZE: rdata = SOC_ROM_SIZE;
      OFS_SYS_FREQ: rdata = SOC_SYS_FREQ;
      OFS_CAPS:     rdata = caps;
      OFS_CYCLO:    rdata = cyc_cnt[31:0];
      OFS_CYCHI:    rdata = cyc_shadow;
      OFS_SCRATCH:  rdata = scratch;
      OFS_SWRST:    rdata = '0;
      OFS_LED:      rdata = DATA_WIDTH'(led_r);
      OFS_BLINK:    rdata = DATA_WIDTH'(blink_r);
      OFS_PERIOD:   rdata = DATA_WIDTH'(period_r);
      default:      rdata = RD_UNMAPPED;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_SResp <= OCP_RESP_NULL;
      o_SData <= '0;
    end else begin
      o_SResp <= (rd || wr) ? OCP_RESP_DVA : OCP_RESP_NULL;
      o_SData <= rd ? rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
      scratch    <= '0;
      led_r      <= '0;
      swrst_cnt  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      // latch the high word so a later CYCHI read pairs with this CYCLO
      if (rd && (req.addr == OFS_CYCLO)) cyc_shadow <= cyc_cnt[63:32];
      if (wr && (req.addr == OFS_SCRATCH))
        scratch <= ben_merge(scratch, req.data, req.ben);
      if (wr && (req.addr == OFS_LED)) led_r <= led_w;
      // a keyed write reloads the count, stretching an active pulse
      if (swrst_hit)              swrst_cnt <= 8'(RST_PULSE);
      else if (swrst_cnt != 8'd0) swrst_cnt <= swrst_cnt - 8'd1;
    end
  end

  assign o_swrst = (swrst_cnt != 8'd0);
  assign o_LED   = led_r & ~(blink_r & {NLED{~phase}});

endmodule

// File: doc/soc_sysctl.md
SOC_SYSCTL -- requirements
Module: soc_sysctl

Interface
REQ-001 SHALL have parameter NLED, default 8: LED output count, legal range 1..32.
REQ-002 SHALL have parameter PRESC_WIDTH, default 24: blink prescaler width, legal range 4..32.
REQ-003 SHALL have parameter RST_PULSE, default 16: software-reset pulse length in cycles, legal range 1..255.
REQ-004 SHALL have one clock and an asynchronous active-low reset; there SHALL be no other clock or reset.
REQ-005 SHALL have port clk, input, width 1: system clock, rising edge.
REQ-006 SHALL have port nrst, input, width 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_MAddr, input, ADDR_WIDTH: OCP address.
REQ-008 SHALL have port i_MCmd, input, width 3: OCP command.
REQ-009 SHALL have port i_MData, input, DATA_WIDTH: OCP write data.
REQ-010 SHALL have port i_MByteEn, input, BEN_WIDTH: OCP byte enables.
REQ-011 SHALL have port o_SCmdAccept, output, width 1: tied to 1.
REQ-012 SHALL have port o_SData, output, DATA_WIDTH: read data, registered.
REQ-013 SHALL have port o_SResp, output, width 2: OCP response, registered.
REQ-014 SHALL have port o_LED, output, NLED: LED drive.
REQ-015 SHALL have port o_swrst, output, width 1: software-reset request, active-high.

Function
REQ-016 SHALL decode this map, all other offsets unmapped:
- 0x000 version, RO
- 0x004 RAM base, RO
- 0x008 RAM size, RO
- 0x00C ROM size, RO
- 0x010 system frequency, RO
- 0x014 CAPS, RO: [5:0]=NLED, [8]=blink present
- 0x020 CYCLO, RO
- 0x024 CYCHI, RO
- 0x030 SCRATCH, RW
- 0x040 SWRST, WO
- 0x100 LED, RW
- 0x104 BLINK mask, RW
- 0x108 PERIOD, RW
REQ-017 SHALL sample each READ or WRITE in the cycle it is presented and SHALL return o_SResp=DVA exactly one cycle later; every other cycle SHALL return o_SResp=NULL with o_SData=0.
REQ-018 SHALL return 0xDEADDEAD on an unmapped read, and SHALL return 0 on a write-only read and on every write response.
REQ-019 SHALL ignore writes to RO and unmapped offsets but still respond DVA.
REQ-020 SHALL update SCRATCH, LED, BLINK and PERIOD only in enabled byte lanes.
REQ-021 SHALL read LED/BLINK bits above NLED-1 as 0 and SHALL discard writes to them.
REQ-022 SHALL increment a free-running 64-bit cycle counter every cycle, wrapping 2^64-1 to 0.
REQ-023 SHALL return the pre-increment counter value on a read in the same cycle as an increment.
REQ-024 SHALL, on a CYCLO read, return counter[31:0] and latch counter[63:32] into a shadow register.
REQ-025 SHALL return the shadow register on a CYCHI read, never the live counter.
REQ-026 SHALL, on a SWRST write with data[7:0]==0xA5 and byte lane 0 enabled, assert o_swrst for exactly RST_PULSE cycles starting the cycle after the write.
REQ-027 SHALL restart the o_swrst count on a keyed write during an active pulse.
REQ-028 SHALL ignore SWRST writes with any other key.
REQ-029 SHALL drive o_LED = LED & ~(BLINK & {NLED{~phase}}).

Reset
REQ-030 SHALL, on nrst low, clear immediately: o_LED=0, o_swrst=0, o_SResp=NULL, o_SData=0, counter=0, shadow=0, SCRATCH=0, LED=0, BLINK=0, PERIOD=0, prescaler=0, phase=1.
REQ-031 SHALL abort a pulse or response in progress on reset, with no residual output after release.

Configuration
REQ-032 SHALL, with SOC_SYSCTL_BLINK_EN defined, run a PRESC_WIDTH prescaler that loads PERIOD, counts down and, on reaching 0, reloads and toggles phase.
REQ-033 SHALL, with SOC_SYSCTL_BLINK_EN defined, hold phase=1 while PERIOD=0, and restart the prescaler from the new value with phase=1 on a PERIOD write.
REQ-034 SHALL, without SOC_SYSCTL_BLINK_EN, hold phase at 1, read BLINK and PERIOD as 0, ignore writes to them, and read CAPS[8] as 0.

Structure
REQ-035 SHALL place register offsets, the 0xA5 key and the 0xDEADDEAD pattern in shared header soc_sysctl.vh, with OCP codes from the existing OCP constants header.
REQ-036 SHALL implement the prescaler and phase toggle in one sub-module, soc_sysctl_blink.

Verification
REQ-037 SHALL verify: after reset, read 0x000..0x010 -> SoC info constants with DVA one cycle later; read 0x014 with NLED=8 and blink on -> 0x108; read 0x200 -> 0xDEADDEAD.
REQ-038 SHALL verify: write LED=0xFFFF_FF3C with byte enables 0b0001 and NLED=8 -> o_LED=0x3C next cycle; read LED -> 0x0000_003C.
REQ-039 SHALL verify: force counter to 0x0000_0001_FFFF_FFFF, read CYCLO -> 0xFFFF_FFFF; read CYCHI 5 cycles later -> 0x0000_0001, not 0x0000_0002.
REQ-040 SHALL verify: write SWRST=0x5A -> no pulse; write 0xA5 -> o_swrst high 16 cycles; rewrite 0xA5 at pulse cycle 10 -> 26 cycles total high.
REQ-041 SHALL verify: LED=0xFF, BLINK=0x0F, PERIOD=3 -> o_LED alternates 0xFF/0xF0 every 4 cycles; PERIOD=0 -> steady 0xFF.
REQ-042 SHALL verify: deassert nrst mid-pulse and mid-blink -> all outputs 0 immediately; after release o_swrst stays 0 and o_LED=0.
